// File: rtl/core_sequencer_if.sv
// Sequencer-side bundle: instruction ROM port, IR/decoder controls, branch inputs
// and the register-file / data-memory strobes.
interface core_sequencer_if #(
  parameter int PC_W = 10
) ();
  logic [PC_W-1:0] imem_addr;
  logic [8:0]      imem_rdata;
  logic [8:0]      ir;
  logic            dec_write_en;
  logic            dec_mem_read;
  logic            dec_mem_write;
  logic [4:0]      dec_alu_op;
  logic            alu_branch_taken;
  logic [7:0]      branch_offset;
  logic            rf_we;
  logic            dmem_re;
  logic            dmem_we;

  modport master (
    output imem_addr, ir, rf_we, dmem_re, dmem_we,
    input  imem_rdata, dec_write_en, dec_mem_read, dec_mem_write,
           dec_alu_op, alu_branch_taken, branch_offset
  );

  modport slave (
    input  imem_addr, ir, rf_we, dmem_re, dmem_we,
    output imem_rdata, dec_write_en, dec_mem_read, dec_mem_write,
           dec_alu_op, alu_branch_taken, branch_offset
  );
endinterface

// File: rtl/core_sequencer.sv
// Multi-cycle fetch/decode/execute/memory sequencer for the 9-bit miniMips core.
// Owns PC and IR, turns decoder controls into one-cycle strobes, stops on HALT.
module core_sequencer #(
  parameter int         PC_W       = 10,
  parameter int         MEM_LAT    = 1,
  parameter logic [8:0] HALT_INSTR = 9'h164
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  core_sequencer_if.master     sif,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_HALT
  } state_t;

  localparam logic [1:0] MEM_LAT_C = 2'(MEM_LAT);

  state_t                 state;
  logic [PC_W-1:0]        pc;
  logic [8:0]             ir_q;
  logic [1:0]             mem_cnt;
  logic                   is_branch;
  logic                   mem_last;
  logic signed [7:0]      off_s;
  logic signed [PC_W-1:0] off_ext;
  logic                   rf_we_c;
  logic                   dmem_re_c;
  logic                   dmem_we_c;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign off_s     = sif.branch_offset;
  assign off_ext   = PC_W'(off_s);
  assign is_branch = (sif.dec_alu_op >= 5'd13) && (sif.dec_alu_op <= 5'd20);
  assign mem_last  = (mem_cnt == MEM_LAT_C);

  // Strobes decode the current state directly so they land in EXEC/MEM and never leak into FETCH.
  always_comb begin
    rf_we_c   = 1'b0;
    dmem_re_c = 1'b0;
    dmem_we_c = 1'b0;
    case (state)
      S_EXEC: begin
        if (is_branch) begin
          rf_we_c = 1'b0;
        end else if (sif.dec_mem_write) begin
          dmem_we_c = 1'b1;
        end else if (sif.dec_mem_read) begin
          dmem_re_c = 1'b1;
        end else begin
          rf_we_c = sif.dec_write_en;
        end
      end
      S_MEM: begin
        dmem_re_c = 1'b1;
        rf_we_c   = mem_last;
      end
      default: ;
    endcase
  end

  assign sif.rf_we     = rf_we_c;
  assign sif.dmem_re   = dmem_re_c;
  assign sif.dmem_we   = dmem_we_c;
  assign sif.imem_addr = pc;
  assign sif.ir        = ir_q;
  assign busy          = (state == S_FETCH) || (state == S_DECODE) ||
                         (state == S_EXEC)  || (state == S_MEM);
  assign done          = (state == S_HALT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      pc          <= '0;
      ir_q        <= '0;
      mem_cnt     <= '0;
      cycle_count <= '0;
    end else begin
      case (state)
        S_IDLE, S_HALT: begin
          if (start) begin
            state       <= S_FETCH;
            pc          <= '0;
            cycle_count <= '0;
          end
        end
        S_FETCH: begin
          cycle_count <= sat_inc(cycle_count);
          state       <= S_DECODE;
        end
        S_DECODE: begin
          cycle_count <= sat_inc(cycle_count);
          ir_q        <= sif.imem_rdata;
          state       <= (sif.imem_rdata == HALT_INSTR) ? S_HALT : S_EXEC;
        end
        S_EXEC: begin
          cycle_count <= sat_inc(cycle_count);
          if (is_branch) begin
            pc    <= sif.alu_branch_taken ? pc + $unsigned(off_ext) : pc + 1'b1;
            state <= S_FETCH;
          end else if (sif.dec_mem_read && !sif.dec_mem_write) begin
            mem_cnt <= 2'd1;
            state   <= S_MEM;
          end else begin
            pc    <= pc + 1'b1;
            state <= S_FETCH;
          end
        end
        S_MEM: begin
          cycle_count <= sat_inc(cycle_count);
          if (mem_last) begin
            pc    <= pc + 1'b1;
            state <= S_FETCH;
          end else begin
            mem_cnt <= mem_cnt + 2'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer (MEM_LAT=2): table of single-instruction
// vectors plus hand-written start/halt/reset/saturation sequences.
module tb_core_sequencer;

  localparam logic [8:0] I_MOV  = 9'h095;
  localparam logic [8:0] I_LDR  = 9'h0A1;
  localparam logic [8:0] I_STR  = 9'h0B2;
  localparam logic [8:0] I_BR13 = 9'h0C3;
  localparam logic [8:0] I_BR20 = 9'h0C4;
  localparam logic [8:0] I_OP12 = 9'h0D5;
  localparam logic [8:0] I_OP21 = 9'h0E6;
  localparam logic [8:0] I_NOP  = 9'h000;
  localparam logic [8:0] I_HALT = 9'h164;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        busy;
  logic        done;
  logic [15:0] cycle_count;
  logic [8:0]  rom [0:1023];

  int errs = 0;
  int checks = 0;

  core_sequencer_if #(.PC_W(10)) sif ();

  core_sequencer #(.PC_W(10), .MEM_LAT(2), .HALT_INSTR(9'h164)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .sif         (sif),
    .busy        (busy),
    .done        (done),
    .cycle_count (cycle_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) sif.imem_rdata <= rom[sif.imem_addr];

  // Stand-in decoder: fixed controls per test encoding.
  always_comb begin
    sif.dec_write_en  = 1'b0;
    sif.dec_mem_read  = 1'b0;
    sif.dec_mem_write = 1'b0;
    sif.dec_alu_op    = 5'd0;
    case (sif.ir)
      I_MOV:  begin sif.dec_write_en = 1'b1; sif.dec_alu_op = 5'd1; end
      I_LDR:  begin sif.dec_write_en = 1'b1; sif.dec_mem_read = 1'b1; end
      I_STR:  sif.dec_mem_write = 1'b1;
      I_BR13: sif.dec_alu_op = 5'd13;
      I_BR20: sif.dec_alu_op = 5'd20;
      I_OP12: begin sif.dec_write_en = 1'b1; sif.dec_alu_op = 5'd12; end
      I_OP21: begin sif.dec_write_en = 1'b1; sif.dec_alu_op = 5'd21; end
      default: ;
    endcase
  end

  typedef struct {
    logic [8:0] instr;
    logic       taken;
    logic [7:0] off;
    logic [9:0] pc;
    logic [9:0] next_pc;
    int         cycles;
    int         n_rf;
    int         n_re;
    int         n_we;
    logic       start_mid;
  } vec_t;

  vec_t vecs [17];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " done"}, 32'(done), 32'd0);
    chk({tag, " pc"}, 32'(sif.imem_addr), 32'd0);
    chk({tag, " ir"}, 32'(sif.ir), 32'd0);
    chk({tag, " count"}, 32'(cycle_count), 32'd0);
    chk({tag, " strobes"}, 32'({sif.rf_we, sif.dmem_re, sif.dmem_we}), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   rf_cnt;
    int   re_cnt;
    int   we_cnt;
    int   rf_at;
    int   bad_phase;
    int   overlap;
    logic [15:0] c0;

    for (int i = 0; i < 1024; i++) rom[i] = I_NOP;
    sif.alu_branch_taken = 1'b0;
    sif.branch_offset    = 8'h00;

    //                instr   tk  off    pc      next    cyc rf re we mid
    vecs[0]  = '{I_MOV,  1'b0, 8'h00, 10'd0,   10'd1,   3, 1, 0, 0, 1'b0};
    vecs[1]  = '{I_LDR,  1'b0, 8'h00, 10'd1,   10'd2,   5, 1, 3, 0, 1'b0};
    vecs[2]  = '{I_STR,  1'b0, 8'h00, 10'd2,   10'd3,   3, 0, 0, 1, 1'b0};
    vecs[3]  = '{I_STR,  1'b0, 8'h00, 10'd3,   10'd4,   3, 0, 0, 1, 1'b1};
    vecs[4]  = '{I_BR13, 1'b1, 8'h06, 10'd4,   10'd10,  3, 0, 0, 0, 1'b0};
    vecs[5]  = '{I_BR13, 1'b1, 8'hFC, 10'd10,  10'd6,   3, 0, 0, 0, 1'b0};
    vecs[6]  = '{I_BR20, 1'b1, 8'h04, 10'd6,   10'd10,  3, 0, 0, 0, 1'b0};
    vecs[7]  = '{I_BR13, 1'b0, 8'hFC, 10'd10,  10'd11,  3, 0, 0, 0, 1'b0};
    vecs[8]  = '{I_BR20, 1'b1, 8'hF5, 10'd11,  10'd0,   3, 0, 0, 0, 1'b0};
    vecs[9]  = '{I_BR13, 1'b1, 8'hFF, 10'd0,   10'h3FF, 3, 0, 0, 0, 1'b0};
    vecs[10] = '{I_MOV,  1'b0, 8'h00, 10'h3FF, 10'd0,   3, 1, 0, 0, 1'b0};
    vecs[11] = '{I_NOP,  1'b0, 8'h00, 10'd0,   10'd1,   3, 0, 0, 0, 1'b0};
    vecs[12] = '{I_OP12, 1'b1, 8'h10, 10'd1,   10'd2,   3, 1, 0, 0, 1'b0};
    vecs[13] = '{I_OP21, 1'b1, 8'h10, 10'd2,   10'd3,   3, 1, 0, 0, 1'b0};
    vecs[14] = '{I_BR13, 1'b1, 8'h7F, 10'd3,   10'd130, 3, 0, 0, 0, 1'b0};
    vecs[15] = '{I_BR13, 1'b1, 8'h80, 10'd130, 10'd2,   3, 0, 0, 0, 1'b0};
    vecs[16] = '{I_LDR,  1'b0, 8'h00, 10'd2,   10'd3,   5, 1, 3, 0, 1'b0};

    // Power-on reset held three cycles
    repeat (3) step();
    chk_idle("por");
    reset = 1'b0;
    step();
    chk_idle("idle");

    // MOV then HALT from a start pulse
    rom[0] = I_MOV;
    rom[1] = I_HALT;
    pulse_start();
    rf_cnt = 0;
    rf_at  = -1;
    for (int k = 0; k < 5; k++) begin
      if (sif.rf_we) begin rf_cnt++; rf_at = k; end
      step();
    end
    chk("mov rf_we pulses", 32'(rf_cnt), 32'd1);
    chk("mov rf_we cycle", 32'(rf_at), 32'd2);
    chk("halt done", 32'(done), 32'd1);
    chk("halt busy", 32'(busy), 32'd0);
    chk("halt count", 32'(cycle_count), 32'd5);
    chk("halt pc", 32'(sif.imem_addr), 32'd1);
    chk("halt ir", 32'(sif.ir), 32'(I_HALT));
    repeat (3) step();
    chk("halt count frozen", 32'(cycle_count), 32'd5);

    // Reset while halted
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    chk_idle("reset in halt");

    // Table of single instructions executed back to back
    pulse_start();
    for (int v = 0; v < 17; v++) begin
      rom[vecs[v].pc]      = vecs[v].instr;
      sif.alu_branch_taken = vecs[v].taken;
      sif.branch_offset    = vecs[v].off;
      chk($sformatf("v%0d fetch pc", v), 32'(sif.imem_addr), 32'(vecs[v].pc));
      c0 = cycle_count;
      rf_cnt = 0; re_cnt = 0; we_cnt = 0; bad_phase = 0; overlap = 0;
      for (int k = 0; k < vecs[v].cycles; k++) begin
        if (sif.rf_we) rf_cnt++;
        if (sif.dmem_re) re_cnt++;
        if (sif.dmem_we) we_cnt++;
        if (sif.rf_we && sif.dmem_we) overlap++;
        if (k < 2 && (sif.rf_we || sif.dmem_re || sif.dmem_we)) bad_phase++;
        start = (vecs[v].start_mid && k == 1);
        step();
      end
      start = 1'b0;
      chk($sformatf("v%0d cycles", v), 32'(cycle_count - c0), 32'(vecs[v].cycles));
      chk($sformatf("v%0d rf_we", v), 32'(rf_cnt), 32'(vecs[v].n_rf));
      chk($sformatf("v%0d dmem_re", v), 32'(re_cnt), 32'(vecs[v].n_re));
      chk($sformatf("v%0d dmem_we", v), 32'(we_cnt), 32'(vecs[v].n_we));
      chk($sformatf("v%0d strobe phase", v), 32'(bad_phase + overlap), 32'd0);
      chk($sformatf("v%0d next pc", v), 32'(sif.imem_addr), 32'(vecs[v].next_pc));
      chk($sformatf("v%0d busy", v), 32'(busy), 32'd1);
    end

    // HALT mid-program: pc not advanced, outputs frozen
    rom[3] = I_HALT;
    repeat (2) step();
    chk("halt2 done", 32'(done), 32'd1);
    chk("halt2 pc", 32'(sif.imem_addr), 32'd3);
    c0 = cycle_count;
    repeat (4) step();
    chk("halt2 count frozen", 32'(cycle_count), 32'(c0));
    chk("halt2 pc frozen", 32'(sif.imem_addr), 32'd3);

    // Restart from HALT, then let NOPs run until the counter saturates
    for (int i = 0; i < 1024; i++) rom[i] = I_NOP;
    pulse_start();
    chk("restart done", 32'(done), 32'd0);
    chk("restart busy", 32'(busy), 32'd1);
    chk("restart pc", 32'(sif.imem_addr), 32'd0);
    chk("restart count", 32'(cycle_count), 32'd0);
    repeat (3) step();
    chk("restart count 3", 32'(cycle_count), 32'd3);
    chk("restart pc 1", 32'(sif.imem_addr), 32'd1);
    repeat (65540) step();
    chk("count saturated", 32'(cycle_count), 32'hFFFF);
    chk("still busy", 32'(busy), 32'd1);

    // Reset while running
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    chk_idle("reset running");

    // Reset in the middle of a load's MEM phase
    rom[0] = I_LDR;
    pulse_start();
    repeat (3) step();
    chk("mid-mem dmem_re", 32'(sif.dmem_re), 32'd1);
    reset = 1'b1;
    step();
    chk_idle("reset mid-mem");
    repeat (2) step();
    reset = 1'b0;
    step();
    chk_idle("after mid-mem");

    // Reset in EXEC of a store suppresses further strobes
    rom[0] = I_STR;
    pulse_start();
    repeat (2) step();
    chk("exec dmem_we", 32'(sif.dmem_we), 32'd1);
    reset = 1'b1;
    step();
    chk_idle("reset mid-exec");
    reset = 1'b0;
    step();
    chk_idle("after mid-exec");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/core_sequencer.md
Name: core_sequencer

Overview:
Multi-cycle control FSM for the 9-bit miniMips core. It owns the PC and fetches from the synchronous instruction ROM into an instruction register (IR). The IR feeds the combinational decoder; the block turns the decoder's static controls into single-cycle strobes for the register file and data memory. It also resolves branches from the ALU's taken flag, detects HALT and reports done/cycle count to the testbench/top level.

Parameters:
PC_W, 10, PC / instruction-ROM address width.
MEM_LAT, 1, data-memory read latency in cycles (legal 1..3).
HALT_INSTR, 9'h164, reserved encoding (jump class, sub-op 1001, reg 00) that halts execution.

Ports:
clk  in  1  clock, all state updates on rising edge.
reset  in  1  synchronous, active-high.
start  in  1  one-cycle pulse, begin execution at PC 0.
imem_addr  out  PC_W  instruction-ROM address (equals pc).
imem_rdata  in  9  ROM data, valid one cycle after address.
ir  out  9  latched instruction, drives decoder.
dec_write_en  in  1  decoder register-write control.
dec_mem_read  in  1  decoder load control.
dec_mem_write  in  1  decoder store control.
dec_alu_op  in  5  decoder ALU operation code.
alu_branch_taken  in  1  ALU branch-condition result for current IR.
branch_offset  in  8  signed PC offset (value of decoded R2 register).
rf_we  out  1  register-file write strobe.
dmem_re  out  1  data-memory read enable.
dmem_we  out  1  data-memory write strobe.
busy  out  1  high from start until HALT.
done  out  1  high in HALT state.
cycle_count  out  16  cycles since start, saturating at 16'hFFFF.

Behaviour:
- Reset, same edge, any state: state=IDLE, pc=0, ir=0, cycle_count=0, all strobes/busy/done=0. Reset mid-instruction aborts it with no strobe.
- States: IDLE, FETCH, DECODE, EXEC, MEM, HALT.
- IDLE: start -> FETCH, pc=0, cycle_count=0.
- FETCH: imem_addr=pc. Next cycle -> DECODE.
- DECODE: ir<=imem_rdata.
  - If imem_rdata==HALT_INSTR -> HALT; pc is not advanced.
  - Otherwise -> EXEC.
- EXEC, decoder controls valid from ir:
  - Branch class is dec_alu_op in 5'd13..5'd20.
    - Taken: pc<=pc+sign_extend(branch_offset), modulo 2^PC_W.
    - Not taken: pc<=pc+1. No strobes; -> FETCH.
  - Store (dec_mem_write): dmem_we=1 this cycle only; pc<=pc+1; -> FETCH.
  - Load (dec_mem_read): dmem_re=1; mem counter=1; -> MEM.
  - Other: rf_we=dec_write_en this cycle; pc<=pc+1; -> FETCH.
- MEM: dmem_re held high.
  - When counter==MEM_LAT: rf_we=1, dmem_re=1, pc<=pc+1, -> FETCH.
  - Otherwise counter++.
- Latency: ALU/branch/store instructions take 3 cycles; load takes 3+MEM_LAT.
- Strobes are high for exactly one cycle per instruction, never in FETCH/DECODE. rf_we and dmem_we are never high together.
- HALT: done=1, busy=0, pc and cycle_count frozen. A start pulse restarts from pc=0 (clears done and count).
- busy=1 in FETCH/DECODE/EXEC/MEM. start is ignored while busy.
- cycle_count increments each cycle while busy. It saturates, with no wrap.
- PC wrap: pc+1 at 2^PC_W-1 gives 0.

Test Plan:
1. Reset held 3 cycles in each state, including mid-MEM -> next cycle IDLE, pc=0, all outputs 0, no strobe after reset edge.
2. ROM = {Mov r1,#5 (9'h095); HALT}; pulse start -> rf_we single pulse on cycle 3 after start; done on cycle 5; cycle_count=5; pc=1.
3. Load with MEM_LAT=2: ldr at pc 0 -> dmem_re high 3 cycles, rf_we on last of them only, next FETCH at pc=1, total 5 cycles.
4. Branch at pc 10, branch_offset=8'hFC, taken=1 -> next imem_addr=6. Repeat with taken=0 -> 11. Repeat at pc 0, offset -1 -> 10'h3FF.
5. Store at pc 3 -> dmem_we exactly 1 cycle, rf_we 0, pc 4. start pulsed mid-run -> ignored, pc unaffected.
6. After HALT, pulse start -> done falls next cycle, fetch resumes at pc 0, cycle_count restarts at 0.
